// File: rtl/bta_frame_sched_if.sv
// rtl/bta_frame_sched_if.sv - operand stream and result port bundle for the BTA frame scheduler
//
// Signals:
//   in_valid/in_ready/in_data/in_last     operand stream, source -> scheduler
//   out_valid/out_ready/out_sum/out_ovf/out_count  result port, scheduler -> consumer
// Modports:
//   master  operand source / result consumer side
//   slave   scheduler side
interface bta_frame_sched_if #(
    parameter int W    = 16,
    parameter int SUMW = W + 3
);
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_data;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [SUMW-1:0] out_sum;
    logic            out_ovf;
    logic [3:0]      out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, out_count
    );
endinterface

// File: rtl/bta_frame_sched.sv
// rtl/bta_frame_sched.sv - frames a serial operand stream onto an 8-input tree adder
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   bus (slave)     operand stream in, frame result out (see bta_frame_sched_if)
//   add_ops         operand bank, slot k = add_ops[k*W +: W], slot 0 = first accepted
//   add_cin         adder carry-in, always 0
//   add_go          one-cycle launch pulse to the adder
//   add_sum         adder result, sampled LAT cycles after add_go
//   add_carry       adder carry-out, reported on out_ovf
//   busy            high whenever a frame is in progress
module bta_frame_sched #(
    parameter int W    = 16,
    parameter int NOPS = 8,
    parameter int LAT  = 2,
    parameter int SUMW = W + 3
) (
    input  logic                clk,
    input  logic                rst_n,
    bta_frame_sched_if.slave    bus,
    output logic [NOPS*W-1:0]   add_ops,
    output logic                add_cin,
    output logic                add_go,
    input  logic [SUMW-1:0]     add_sum,
    input  logic                add_carry,
    output logic                busy
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_LAUNCH,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [3:0]               wcnt_q, wcnt_d;
    logic [NOPS-1:0][W-1:0]   ops_q, ops_d;
    logic [SUMW-1:0]          sum_q, sum_d;
    logic                     ovf_q, ovf_d;
    logic [3:0]               count_q, count_d;

    logic accept;
    logic frame_end;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            ops_q   <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            ops_q   <= ops_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wcnt_d       = wcnt_q;
        ops_d        = ops_q;
        sum_d        = sum_q;
        ovf_d        = ovf_q;
        count_d      = count_q;
        add_go       = 1'b0;
        bus.in_ready = (state_q == S_IDLE) || (state_q == S_FILL);
        bus.out_valid = 1'b0;
        accept       = bus.in_valid && bus.in_ready;
        frame_end    = accept && (bus.in_last || (cnt_q == 4'(NOPS - 1)));

        case (state_q)
            S_IDLE, S_FILL: begin
                if (accept) begin
                    // Slots above the write position are zeroed at frame end so a
                    // short frame never sums leftovers from the previous one.
                    for (int k = 0; k < NOPS; k++) begin
                        if (4'(k) == cnt_q) begin
                            ops_d[k] = bus.in_data;
                        end else if (frame_end && (4'(k) > cnt_q)) begin
                            ops_d[k] = '0;
                        end
                    end
                    cnt_d   = cnt_q + 4'd1;
                    state_d = frame_end ? S_LAUNCH : S_FILL;
                end
            end
            S_LAUNCH: begin
                add_go  = 1'b1;
                wcnt_d  = 4'(LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Counter reaches 0 in the cycle LAT after add_go; capture on that edge.
                if (wcnt_q == 4'd0) begin
                    sum_d   = add_sum;
                    ovf_d   = add_carry;
                    count_d = cnt_q;
                    state_d = S_HOLD;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign add_ops       = ops_q;
    assign add_cin       = 1'b0;
    assign busy          = (state_q != S_IDLE);
    assign bus.out_sum   = sum_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_count = count_q;
endmodule

// File: tb/tb_bta_frame_sched.sv
// tb/tb_bta_frame_sched.sv - self-checking bench for bta_frame_sched
module tb_bta_frame_sched;
    localparam int W    = 16;
    localparam int NOPS = 8;
    localparam int LAT  = 2;
    localparam int SUMW = W + 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bta_frame_sched_if #(.W(W), .SUMW(SUMW)) bus();

    logic [NOPS*W-1:0] add_ops;
    logic              add_cin, add_go, add_carry, busy;
    logic [SUMW-1:0]   add_sum;

    bta_frame_sched #(.W(W), .NOPS(NOPS), .LAT(LAT), .SUMW(SUMW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .add_ops   (add_ops),
        .add_cin   (add_cin),
        .add_go    (add_go),
        .add_sum   (add_sum),
        .add_carry (add_carry),
        .busy      (busy)
    );

    int tests = 0;
    int fails = 0;

    // Adder model: result is valid only in the cycle exactly LAT after add_go,
    // and the inverted value is presented at every other time.
    logic [3:0]      pipe_cnt;
    logic [SUMW-1:0] pipe_sum;
    logic            tb_carry = 1'b0;

    function automatic logic [SUMW-1:0] tree_sum(input logic [NOPS*W-1:0] v);
        logic [SUMW-1:0] s = '0;
        for (int k = 0; k < NOPS; k++) s += SUMW'(v[k*W +: W]);
        return s;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            pipe_cnt <= '0;
            pipe_sum <= '0;
        end else if (add_go) begin
            pipe_cnt <= 4'd1;
            pipe_sum <= tree_sum(add_ops);
        end else if (pipe_cnt != 0 && pipe_cnt < 4'd15) begin
            pipe_cnt <= pipe_cnt + 4'd1;
        end
    end
    assign add_sum   = (pipe_cnt == 4'(LAT)) ? pipe_sum : ~pipe_sum;
    assign add_carry = (pipe_cnt == 4'(LAT)) ? tb_carry : ~tb_carry;

    // Monitor
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int                go_cnt = 0, go_cyc = 0, ov_rise = 0, ov_high = 0, ops_changes = 0;
    logic [NOPS*W-1:0] go_ops = '0;
    logic              prev_ov = 1'b0, after_go = 1'b0;
    always @(negedge clk) begin
        if (add_go) begin
            go_cnt++;
            go_cyc   = cyc;
            go_ops   = add_ops;
            after_go = 1'b1;
        end else if (after_go && busy && add_ops !== go_ops) begin
            ops_changes++;
        end
        if (!busy) after_go = 1'b0;
        if (bus.out_valid) ov_high++;
        if (bus.out_valid && !prev_ov) ov_rise++;
        prev_ov = bus.out_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus helpers (no checking here)
    task automatic send_frame(input int n, input logic [W-1:0] ops[NOPS], input bit stall,
                              input bit last_final, output int first_c, output bit ok);
        int i = 0;
        int guard = 0;
        ok = 1'b1;
        first_c = -1;
        while (i < n) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                ok = 1'b0;
                break;
            end
            if (stall && $urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = W'($urandom);
                bus.in_last  = 1'($urandom);
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = ops[i];
                bus.in_last  = (i == n - 1) ? last_final : 1'b0;
                if (bus.in_ready) begin
                    if (i == 0) first_c = cyc;
                    i++;
                end
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_result(output bit ok, output int c);
        ok = 1'b0;
        c = -1;
        for (int g = 0; g < 100; g++) begin
            if (bus.out_valid) begin
                ok = 1'b1;
                c = cyc;
                return;
            end
            @(negedge clk);
        end
    endtask

    function automatic logic [NOPS*W-1:0] ref_bank(input int n, input logic [W-1:0] ops[NOPS]);
        logic [NOPS*W-1:0] b = '0;
        for (int k = 0; k < n; k++) b[k*W +: W] = ops[k];
        return b;
    endfunction

    function automatic logic [SUMW-1:0] ref_sum(input int n, input logic [W-1:0] ops[NOPS]);
        logic [SUMW-1:0] s = '0;
        for (int k = 0; k < n; k++) s += SUMW'(ops[k]);
        return s;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({bus.out_valid, add_go, busy, bus.out_ovf} !== 4'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b want 0000", {bus.out_valid, add_go, busy, bus.out_ovf});
        end
        tests++;
        if (add_ops !== '0 || bus.out_sum !== '0 || bus.out_count !== 4'd0) begin
            fails++;
            $display("FAIL reset_data: ops=%h sum=%h count=%0d want all 0", add_ops, bus.out_sum, bus.out_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_full_frame();
        logic [W-1:0] ops[NOPS];
        int first_c, res_c, oh;
        bit ok, okr;
        for (int k = 0; k < NOPS; k++) ops[k] = W'(k + 1);
        bus.out_ready = 1'b1;
        oh = ov_high;
        send_frame(8, ops, 1'b0, 1'b1, first_c, ok);
        wait_result(okr, res_c);
        tests++;
        if (!(ok && okr)) begin
            fails++;
            $display("FAIL full_timeout: send=%b result=%b want 1/1", ok, okr);
        end
        tests++;
        if (go_cyc !== first_c + 8 || res_c !== first_c + 9 + LAT) begin
            fails++;
            $display("FAIL full_latency: go=%0d valid=%0d want %0d/%0d", go_cyc - first_c, res_c - first_c, 8, 9 + LAT);
        end
        tests++;
        if (bus.out_sum !== 19'd36 || bus.out_count !== 4'd8 || bus.out_ovf !== 1'b0) begin
            fails++;
            $display("FAIL full_result: sum=%0d count=%0d ovf=%b want 36/8/0", bus.out_sum, bus.out_count, bus.out_ovf);
        end
        tests++;
        if (go_ops !== ref_bank(8, ops)) begin
            fails++;
            $display("FAIL full_bank: got %h want %h", go_ops, ref_bank(8, ops));
        end
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b0 || ov_high - oh !== 1) begin
            fails++;
            $display("FAIL full_one_cycle: valid=%b high_cycles=%0d want 0/1", bus.out_valid, ov_high - oh);
        end
    endtask

    task automatic test_short_frame();
        logic [W-1:0] ops[NOPS];
        int first_c, res_c;
        bit ok, okr;
        for (int k = 0; k < NOPS; k++) ops[k] = '0;
        ops[0] = 16'd5; ops[1] = 16'd7; ops[2] = 16'd9;
        send_frame(3, ops, 1'b0, 1'b1, first_c, ok);
        wait_result(okr, res_c);
        tests++;
        if (!(ok && okr) || go_ops !== ref_bank(3, ops)) begin
            fails++;
            $display("FAIL short_bank: got %h want %h ok=%b%b", go_ops, ref_bank(3, ops), ok, okr);
        end
        tests++;
        if (bus.out_sum !== 19'd21 || bus.out_count !== 4'd3) begin
            fails++;
            $display("FAIL short_result: sum=%0d count=%0d want 21/3", bus.out_sum, bus.out_count);
        end
        @(negedge clk);
    endtask

    task automatic test_max_operands();
        logic [W-1:0] ops[NOPS];
        int first_c, res_c;
        bit ok, okr;
        for (int k = 0; k < NOPS; k++) ops[k] = 16'hFFFF;
        send_frame(8, ops, 1'b0, 1'b1, first_c, ok);
        wait_result(okr, res_c);
        tests++;
        if (!(ok && okr) || bus.out_sum !== 19'h7FFF8 || bus.out_ovf !== 1'b0) begin
            fails++;
            $display("FAIL max_result: sum=%h ovf=%b want 7fff8/0", bus.out_sum, bus.out_ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_hold_backpressure();
        logic [W-1:0] ops[NOPS];
        logic [SUMW-1:0] es;
        int first_c, res_c, gc, bad;
        bit ok, okr;
        for (int k = 0; k < NOPS; k++) ops[k] = W'($urandom);
        es = ref_sum(4, ops);
        bus.out_ready = 1'b0;
        send_frame(4, ops, 1'b0, 1'b1, first_c, ok);
        wait_result(okr, res_c);
        gc = go_cnt;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = W'($urandom);
            bus.in_last  = 1'b1;
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_sum !== es || bus.in_ready !== 1'b0) bad++;
        end
        tests++;
        if (!(ok && okr) || bad != 0) begin
            fails++;
            $display("FAIL hold_stable: bad_cycles=%0d ok=%b%b sum=%h want 0 with sum %h", bad, ok, okr, bus.out_sum, es);
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b0 || go_cnt !== gc || bus.out_sum !== es || bus.out_count !== 4'd4) begin
            fails++;
            $display("FAIL hold_release: valid=%b new_go=%0d sum=%h count=%0d want 0/0/%h/4",
                     bus.out_valid, go_cnt - gc, bus.out_sum, bus.out_count, es);
        end
    endtask

    task automatic test_single();
        logic [W-1:0] ops[NOPS];
        int first_c, res_c;
        bit ok, okr;
        for (int k = 0; k < NOPS; k++) ops[k] = '0;
        ops[0] = 16'h1234;
        send_frame(1, ops, 1'b0, 1'b1, first_c, ok);
        wait_result(okr, res_c);
        tests++;
        if (!(ok && okr) || go_cyc !== first_c + 1 || go_ops !== ref_bank(1, ops)) begin
            fails++;
            $display("FAIL single_launch: go_offset=%0d bank=%h want 1/%h", go_cyc - first_c, go_ops, ref_bank(1, ops));
        end
        tests++;
        if (bus.out_sum !== 19'h1234 || bus.out_count !== 4'd1) begin
            fails++;
            $display("FAIL single_result: sum=%h count=%0d want 1234/1", bus.out_sum, bus.out_count);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        logic [W-1:0] ops[NOPS];
        int first_c, res_c, r0, g0;
        bit ok, okr;
        for (int k = 0; k < NOPS; k++) ops[k] = W'($urandom | 1);
        bus.out_ready = 1'b1;
        send_frame(4, ops, 1'b0, 1'b0, first_c, ok);
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || add_ops !== '0 || bus.out_valid !== 1'b0 || bus.out_count !== 4'd0) begin
            fails++;
            $display("FAIL midreset_clear: busy=%b ops=%h valid=%b count=%0d want 0", busy, add_ops, bus.out_valid, bus.out_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL midreset_ready: got %b want 1", bus.in_ready);
        end
        r0 = ov_rise;
        g0 = go_cnt;
        repeat (12) @(negedge clk);
        tests++;
        if (ov_rise !== r0 || go_cnt !== g0) begin
            fails++;
            $display("FAIL midreset_stale: valid_pulses=%0d launches=%0d want 0/0", ov_rise - r0, go_cnt - g0);
        end
        ops[0] = 16'd3; ops[1] = 16'd4;
        send_frame(2, ops, 1'b0, 1'b1, first_c, ok);
        wait_result(okr, res_c);
        tests++;
        if (!(ok && okr) || bus.out_sum !== 19'd7 || bus.out_count !== 4'd2) begin
            fails++;
            $display("FAIL midreset_next: sum=%0d count=%0d want 7/2", bus.out_sum, bus.out_count);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [W-1:0] ops[NOPS];
        logic [SUMW-1:0] es;
        int n, first_c, res_c, oc, bad;
        bit ok, okr, stall, lf, rdy;
        oc = ops_changes;
        for (int f = 0; f < 16; f++) begin
            n = $urandom_range(1, NOPS);
            for (int k = 0; k < NOPS; k++) ops[k] = W'($urandom);
            stall = 1'($urandom);
            lf = (n < NOPS) ? 1'b1 : 1'($urandom);
            tb_carry = ($urandom_range(0, 3) == 0);
            rdy = 1'($urandom);
            bus.out_ready = rdy;
            es = ref_sum(n, ops);
            send_frame(n, ops, stall, lf, first_c, ok);
            wait_result(okr, res_c);
            tests++;
            if (!(ok && okr) || bus.out_sum !== es || bus.out_count !== 4'(n) || bus.out_ovf !== tb_carry) begin
                fails++;
                $display("FAIL rand_result[%0d]: sum=%h count=%0d ovf=%b want %h/%0d/%b",
                         f, bus.out_sum, bus.out_count, bus.out_ovf, es, n, tb_carry);
            end
            tests++;
            if (go_ops !== ref_bank(n, ops) || res_c !== go_cyc + LAT + 1 ||
                (!stall && go_cyc !== first_c + n)) begin
                fails++;
                $display("FAIL rand_timing[%0d]: bank=%h go_off=%0d valid_off=%0d want %h/%0d/%0d",
                         f, go_ops, go_cyc - first_c, res_c - go_cyc, ref_bank(n, ops), n, LAT + 1);
            end
            bad = 0;
            if (!rdy) begin
                repeat ($urandom_range(1, 4)) begin
                    @(negedge clk);
                    if (bus.out_valid !== 1'b1 || bus.out_sum !== es) bad++;
                end
                bus.out_ready = 1'b1;
            end
            @(negedge clk);
            tests++;
            if (bad != 0 || bus.out_valid !== 1'b0) begin
                fails++;
                $display("FAIL rand_handshake[%0d]: unstable=%0d valid_after=%b want 0/0", f, bad, bus.out_valid);
            end
        end
        tb_carry = 1'b0;
        tests++;
        if (ops_changes !== oc) begin
            fails++;
            $display("FAIL rand_bank_stable: changes=%0d want 0", ops_changes - oc);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_full_frame();
        test_short_frame();
        test_max_operands();
        test_hold_backpressure();
        test_single();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
